// File: rtl/qos_egress_drain.sv
// ----------------------------------------------------------------------------
// qos_egress_drain
//
// Drains four upstream FIFOs into one downstream valid/ready stream. One word
// is moved per transaction: the FSM selects a non-empty FIFO, pulses its pop
// strobe, captures the word on the following cycle and holds it until the
// downstream accepts it. A per-FIFO transfer counter records completed
// transfers and can be read back through a small request port.
//
// Build option:
//   QOS_STRICT_PRIO_EN - when defined, arbitration is fixed priority (the
//                        lowest-index non-empty FIFO wins) and rr_ptr stays 0.
//                        When undefined, arbitration is round-robin.
//
// Ports:
//   clk                  rising-edge clock
//   reset                asynchronous active-high reset
//   init                 synchronous clear of counters, pointer and FSM
//   fifo_empty[3:0]      per-FIFO empty flags
//   fifo_dataout0..3     FIFO read data, valid one cycle after the pop
//   popBP0..3            one-cycle read strobe to each FIFO
//   out_data/out_valid   word offered downstream
//   out_ready            downstream accept
//   req/idx              counter read request and index (4..7 read as 0)
//   data/valid           counter read result, one cycle after req
//   idle_out             FSM idle and all FIFOs empty
// ----------------------------------------------------------------------------
module qos_egress_drain #(
  parameter int DATA_WIDTH = 12,
  parameter int CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  init,
  input  logic [3:0]            fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_dataout0,
  input  logic [DATA_WIDTH-1:0] fifo_dataout1,
  input  logic [DATA_WIDTH-1:0] fifo_dataout2,
  input  logic [DATA_WIDTH-1:0] fifo_dataout3,
  output logic                  popBP0,
  output logic                  popBP1,
  output logic                  popBP2,
  output logic                  popBP3,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  req,
  input  logic [2:0]            idx,
  output logic [CNT_WIDTH-1:0]  data,
  output logic                  valid,
  output logic                  idle_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    CAP  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t                state;
  logic [1:0]            grant;
  logic [1:0]            rr_ptr;
  logic [1:0]            winner;
  logic [3:0]            pop;
  logic [CNT_WIDTH-1:0]  count [4];
  logic [DATA_WIDTH-1:0] sel_data;

  // Arbitration: pick the FIFO to serve from the empty flags seen in IDLE.
  // Only non-empty FIFOs can win, so a pop never targets an empty FIFO.
`ifdef QOS_STRICT_PRIO_EN
  always_comb begin
    winner = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!fifo_empty[i]) winner = 2'(i);
    end
  end
`else
  logic       found;
  logic [1:0] cand;

  always_comb begin
    winner = rr_ptr;
    found  = 1'b0;
    cand   = rr_ptr;
    for (int i = 0; i < 4; i++) begin
      cand = rr_ptr + 2'(i);
      if (!found && !fifo_empty[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end
`endif

  // Read-data mux for the granted FIFO; used in CAP, one cycle after the pop.
  always_comb begin
    case (grant)
      2'd0:    sel_data = fifo_dataout0;
      2'd1:    sel_data = fifo_dataout1;
      2'd2:    sel_data = fifo_dataout2;
      default: sel_data = fifo_dataout3;
    endcase
  end

  // Main FSM, counters and the counter read port. The read port samples the
  // counters before any coincident increment or init clear lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= 2'd0;
      rr_ptr    <= 2'd0;
      pop       <= 4'b0000;
      out_data  <= '0;
      out_valid <= 1'b0;
      data      <= '0;
      valid     <= 1'b0;
      for (int k = 0; k < 4; k++) count[k] <= '0;
    end else begin
      valid <= req;
      data  <= (req && !idx[2]) ? count[idx[1:0]] : '0;

      if (init) begin
        // A pop already on the wire finishes on its own; dropping to IDLE
        // here means its word is never captured.
        state     <= IDLE;
        rr_ptr    <= 2'd0;
        pop       <= 4'b0000;
        out_data  <= '0;
        out_valid <= 1'b0;
        for (int k = 0; k < 4; k++) count[k] <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (fifo_empty != 4'b1111) begin
              grant <= winner;
              pop   <= 4'b0001 << winner;
              state <= POP;
            end
          end
          POP: begin
            pop   <= 4'b0000;
            state <= CAP;
          end
          CAP: begin
            out_data  <= sel_data;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
          HOLD: begin
            if (out_ready) begin
              out_valid    <= 1'b0;
              count[grant] <= count[grant] + 1'b1;
`ifdef QOS_STRICT_PRIO_EN
              rr_ptr       <= 2'd0;
`else
              rr_ptr       <= grant + 2'd1;
`endif
              state        <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign popBP0 = pop[0];
  assign popBP1 = pop[1];
  assign popBP2 = pop[2];
  assign popBP3 = pop[3];

  // Reset forces the FSM to IDLE asynchronously, so during reset this simply
  // tracks the empty flags.
  assign idle_out = (state == IDLE) && (fifo_empty == 4'b1111);

endmodule
